// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/mode capture and display bus for seg7_scan_driver
//  load      capture request for data/mode
//  data      unsigned value to display
//  mode      00 octal, 01 hex, 10 decimal, 11 hex
//  blank_lz  blank leading zero digits, sampled live
//  busy      conversion in progress, load ignored
//  done      one-cycle pulse when new digits take effect
//  ovf       captured value does not fit in DIGITS digits
//  seg       segments, seg[0]=a .. seg[6]=g
//  an        one-hot digit select
interface seg7_scan_driver_if #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
);
   logic              load;
   logic [DATA_W-1:0] data;
   logic [1:0]        mode;
   logic              blank_lz;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   modport master (output load, data, mode, blank_lz, input busy, done, ovf, seg, an);
   modport slave  (input load, data, mode, blank_lz, output busy, done, ovf, seg, an);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multi-digit 7-segment scan driver with octal/hex/decimal rendering
//  clk   system clock, rising edge
//  rst   synchronous reset, active-high
//  bus   seg7_scan_driver_if slave: load/data/mode/blank_lz in, busy/done/ovf/seg/an out
module seg7_scan_driver #(
   parameter int DATA_W      = 8,
   parameter int DIGITS      = 3,
   parameter int SCAN_DIV    = 50000,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_driver_if.slave bus
);
   // ceil(DATA_W/3) digits always cover both the octal and the decimal rendering
   localparam int BCD_N = (DATA_W + 2) / 3;
   localparam int ND    = BCD_N > DIGITS ? BCD_N : DIGITS;
   localparam int CW    = $clog2(DATA_W + 1);
   localparam int PW    = $clog2(SCAN_DIV + 1);
   localparam int IW    = $clog2(DIGITS + 1);
   localparam logic [6:0]        SINV = SEG_ACT_LOW != 0 ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] AINV = AN_ACT_LOW != 0 ? '1 : '0;
   localparam logic [6:0]        DASH = 7'h40;
   localparam logic [15:0][6:0]  GLYPH = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                          7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
   typedef enum logic [1:0] {S_IDLE, S_ONE, S_DEC} state_t;
   state_t              state, nxt;
   logic                accept, commit, octf;
   logic [DATA_W-1:0]   sh;
   logic [4*BCD_N-1:0]  bcd, adj, nxt_bcd;
   logic [CW-1:0]       cnt;
   logic [3*ND-1:0]     op;
   logic [4*ND-1:0]     res;
   logic [4*DIGITS-1:0] digits, up;
   logic                ovf_r, done_r, blank;
   logic [PW-1:0]       pre;
   logic [IW-1:0]       idx;
   logic [6:0]          seg_r, glyph;
   logic [DIGITS-1:0]   an_r;
   assign accept = bus.load && state == S_IDLE;
   always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;
   always_comb begin
      nxt    = state;
      commit = 1'b0;
      if (accept) nxt = bus.mode == 2'b10 ? S_DEC : S_ONE;
      if (state == S_ONE || (state == S_DEC && cnt == CW'(DATA_W - 1))) begin
         nxt    = S_IDLE;
         commit = 1'b1;
      end
   end
   // one double-dabble step; the last step's result is committed directly
   always_comb begin
      adj = bcd;
      for (int j = 0; j < BCD_N; j++)
         adj[4*j +: 4] = bcd[4*j +: 4] >= 4'd5 ? bcd[4*j +: 4] + 4'd3 : bcd[4*j +: 4];
      nxt_bcd = {adj[4*BCD_N-2:0], sh[DATA_W-1]};
      op = '0;
      op[DATA_W-1:0] = sh;
      res = '0;
      if (state == S_DEC) res[4*BCD_N-1:0] = nxt_bcd;
      else if (octf) for (int j = 0; j < ND; j++) res[4*j +: 4] = {1'b0, op[3*j +: 3]};
      else res[DATA_W-1:0] = sh;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh     <= '0;
         bcd    <= '0;
         cnt    <= '0;
         octf   <= 1'b0;
         digits <= '0;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= commit;
         if (commit) begin
            digits <= res[4*DIGITS-1:0];
            ovf_r  <= |(res >> (4*DIGITS));
         end
         if (accept) begin
            sh   <= bus.data;
            bcd  <= '0;
            cnt  <= '0;
            octf <= bus.mode == 2'b00;
         end else if (state == S_DEC) begin
            bcd <= nxt_bcd;
            sh  <= sh << 1;
            cnt <= cnt + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= pre == PW'(SCAN_DIV - 1) ? '0 : pre + 1'b1;
         if (pre == PW'(SCAN_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      end
   end
   // up holds digits idx..DIGITS-1, so up==0 means the selected digit is a leading zero
   assign up    = digits >> {idx, 2'b00};
   assign glyph = ovf_r ? DASH : GLYPH[up[3:0]];
   assign blank = bus.blank_lz && idx != '0 && up == '0 && !ovf_r;
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_r <= SINV;
         an_r  <= AINV;
      end else begin
         seg_r <= (blank ? 7'h00 : glyph) ^ SINV;
         an_r  <= (DIGITS'(1) << idx) ^ AINV;
      end
   end
   assign bus.busy = state != S_IDLE;
   assign bus.done = done_r;
   assign bus.ovf  = ovf_r;
   assign bus.seg  = seg_r;
   assign bus.an   = an_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vector bench for seg7_scan_driver (8-bit and 12-bit instances)
module tb_seg7_scan_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   seg7_scan_driver_if #(.DATA_W(8),  .DIGITS(3)) busa ();
   seg7_scan_driver_if #(.DATA_W(12), .DIGITS(3)) busb ();
   seg7_scan_driver #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1))
      dut_a (.clk(clk), .rst(rst), .bus(busa));
   seg7_scan_driver #(.DATA_W(12), .DIGITS(3), .SCAN_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1))
      dut_b (.clk(clk), .rst(rst), .bus(busb));
   int tests = 0;
   int fails = 0;
   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic       blz;
      int         cyc;
      logic [6:0] s0, s1, s2;
   } vec_t;
   vec_t vecs [10];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic logic f_busy(input bit b); return b ? busb.busy : busa.busy; endfunction
   function automatic logic f_done(input bit b); return b ? busb.done : busa.done; endfunction
   function automatic logic [6:0] f_seg(input bit b); return b ? busb.seg : busa.seg; endfunction
   function automatic logic [2:0] f_an(input bit b); return b ? busb.an : busa.an; endfunction
   task automatic load(input bit b, input logic [11:0] d, input logic [1:0] m);
      @(negedge clk);
      if (b) begin
         busb.load = 1'b1;
         busb.data = d;
         busb.mode = m;
      end else begin
         busa.load = 1'b1;
         busa.data = d[7:0];
         busa.mode = m;
      end
      @(negedge clk);
      busa.load = 1'b0;
      busb.load = 1'b0;
   endtask
   task automatic run_busy(input bit b, input string name, input int exp_cyc);
      int n = 0;
      bit early = 1'b0;
      while (f_busy(b) && n < 64) begin
         n++;
         if (f_done(b)) early = 1'b1;
         @(negedge clk);
      end
      check($sformatf("%s busy cycles", name), n, exp_cyc);
      check($sformatf("%s done at busy fall", name), {early, f_done(b)}, 2'b01);
   endtask
   task automatic read_seg(input bit b, input int k, output logic [6:0] s);
      int n = 0;
      logic [2:0] want;
      want = ~(3'b001 << k);
      @(negedge clk);
      while (f_an(b) != want && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) check($sformatf("scan timeout digit %0d", k), n, 0);
      s = f_seg(b);
   endtask
   task automatic check_digits(input bit b, input string name, input logic [6:0] e0, e1, e2);
      logic [6:0] s;
      read_seg(b, 0, s);
      check($sformatf("%s seg idx0", name), s, e0);
      read_seg(b, 1, s);
      check($sformatf("%s seg idx1", name), s, e1);
      read_seg(b, 2, s);
      check($sformatf("%s seg idx2", name), s, e2);
   endtask
   int n;
   bit flag;
   initial begin
      vecs[0] = '{8'hFF, 2'b00, 1'b0, 1, 7'h78, 7'h78, 7'h30};
      vecs[1] = '{8'd255, 2'b10, 1'b0, 8, 7'h12, 7'h12, 7'h24};
      vecs[2] = '{8'h0A, 2'b01, 1'b1, 1, 7'h08, 7'h7F, 7'h7F};
      vecs[3] = '{8'h0A, 2'b01, 1'b0, 1, 7'h08, 7'h40, 7'h40};
      vecs[4] = '{8'h00, 2'b10, 1'b1, 8, 7'h40, 7'h7F, 7'h7F};
      vecs[5] = '{8'hFF, 2'b01, 1'b1, 1, 7'h0E, 7'h0E, 7'h7F};
      vecs[6] = '{8'd100, 2'b10, 1'b1, 8, 7'h40, 7'h40, 7'h79};
      vecs[7] = '{8'hC8, 2'b00, 1'b0, 1, 7'h40, 7'h79, 7'h30};
      vecs[8] = '{8'h5B, 2'b11, 1'b0, 1, 7'h03, 7'h12, 7'h40};
      vecs[9] = '{8'h7F, 2'b10, 1'b0, 8, 7'h78, 7'h24, 7'h79};
      busa.load = 1'b0; busa.data = '0; busa.mode = '0; busa.blank_lz = 1'b0;
      busb.load = 1'b0; busb.data = '0; busb.mode = '0; busb.blank_lz = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset seg", busa.seg, 7'h7F);
      check("reset an", busa.an, 3'b111);
      check("reset busy", busa.busy, 1'b0);
      check("reset done/ovf", {busa.done, busa.ovf}, 2'b00);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset seg", busa.seg, 7'h40);
      check("post-reset an", busa.an, 3'b110);
      n = 0;
      do begin @(negedge clk); n++; end while (busa.an != 3'b101 && n < 20);
      check("scan period idx1", n, 4);
      n = 0;
      do begin @(negedge clk); n++; end while (busa.an != 3'b011 && n < 20);
      check("scan period idx2", n, 4);
      for (int i = 0; i < 10; i++) begin
         busa.blank_lz = vecs[i].blz;
         load(1'b0, {4'h0, vecs[i].data}, vecs[i].mode);
         run_busy(1'b0, $sformatf("v%0d", i), vecs[i].cyc);
         check($sformatf("v%0d ovf", i), busa.ovf, 1'b0);
         check_digits(1'b0, $sformatf("v%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2);
      end
      busa.blank_lz = 1'b0;
      load(1'b0, 12'h0FF, 2'b00);
      run_busy(1'b0, "oct ff", 1);
      load(1'b0, 12'd255, 2'b10);
      n = 0;
      flag = 1'b0;
      while (busa.busy && n < 64) begin
         n++;
         if (busa.seg !== (busa.an == 3'b011 ? 7'h30 : 7'h78)) flag = 1'b1;
         @(negedge clk);
      end
      check("old digits held while busy", flag, 1'b0);
      check("dec 255 busy cycles", n, 8);
      check("dec 255 done", busa.done, 1'b1);
      check_digits(1'b0, "dec 255", 7'h12, 7'h12, 7'h24);
      load(1'b0, 12'd100, 2'b10);
      n = 0;
      while (busa.busy && n < 64) begin
         n++;
         if (n == 3) begin
            busa.load = 1'b1;
            busa.data = 8'h0A;
            busa.mode = 2'b01;
         end else busa.load = 1'b0;
         @(negedge clk);
      end
      busa.load = 1'b0;
      check("load during busy cycles", n, 8);
      check("load during busy done", busa.done, 1'b1);
      check_digits(1'b0, "load during busy", 7'h40, 7'h40, 7'h79);
      load(1'b0, 12'd255, 2'b10);
      n = 0;
      while (busa.busy && n < 3) begin
         n++;
         @(negedge clk);
      end
      check("busy before abort", busa.busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy/done", {busa.busy, busa.done}, 2'b00);
      check("abort seg/an", {busa.seg, busa.an}, {7'h7F, 3'b111});
      flag = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (busa.busy || busa.done) flag = 1'b1;
      end
      check("no busy/done after abort", flag, 1'b0);
      check_digits(1'b0, "after abort", 7'h40, 7'h40, 7'h40);
      load(1'b1, 12'd1234, 2'b10);
      run_busy(1'b1, "b 1234", 12);
      check("b 1234 ovf", busb.ovf, 1'b1);
      check_digits(1'b1, "b 1234", 7'h3F, 7'h3F, 7'h3F);
      busb.blank_lz = 1'b1;
      load(1'b1, 12'd1000, 2'b10);
      run_busy(1'b1, "b 1000", 12);
      check("b 1000 ovf", busb.ovf, 1'b1);
      check_digits(1'b1, "b 1000", 7'h3F, 7'h3F, 7'h3F);
      load(1'b1, 12'd999, 2'b10);
      run_busy(1'b1, "b 999", 12);
      check("b 999 ovf", busb.ovf, 1'b0);
      check_digits(1'b1, "b 999", 7'h10, 7'h10, 7'h10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
